anc_fir_sched: RTL and testbench
================================

Name: anc_fir_sched

Overview:
Two-requester scheduler that time-shares one FIR/LMS engine (fir_go/fir_done handshake) between two ANC channels.
- Each channel deposits one sample set (x, a, weight_adjust) into a depth-1 holding slot.
- The scheduler grants channels round-robin, drives the engine, and returns the result tagged with the channel number.
- A watchdog recovers the scheduler if the engine never signals done.

Parameters:
DW, 16, sample/weight data width
TIMEOUT_CYC, 1024, max cycles in WAIT before abort (>=2)
CW, 10, watchdog counter width (2^CW >= TIMEOUT_CYC)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
sched_en  in  1  1 = grants allowed; 0 = no new grants, in-flight op completes
ch_valid  in  2  per-channel sample-set valid
ch_ready  out  2  per-channel slot empty
ch0_x, ch1_x  in  DW each  channel reference sample (signed)
ch0_a, ch1_a  in  DW each  channel desired sample (signed)
ch0_w, ch1_w  in  DW each  channel weight_adjust (signed)
fir_go  out  1  one-cycle start pulse to engine
fir_x, fir_a, fir_w  out  DW each  issued operands, held stable from fir_go until op ends
fir_done  in  1  engine completion pulse
fir_out  in  DW  engine output sample, valid with fir_done
out_valid  out  1  one-cycle result strobe
out_sample  out  DW  registered result
out_chan  out  1  channel that produced out_sample
busy  out  1  state != IDLE
err_timeout  out  1  sticky watchdog flag
err_clr  in  1  clears err_timeout

Behaviour:
- Reset values: all outputs 0 except ch_ready=2'b11. Slots empty, state IDLE, last_grant=1 (so ch0 wins the first tie), watchdog=0.
- Slot i accepts on ch_valid[i] & ch_ready[i]; slot full from the next cycle. ch_ready[i] = ~full[i] (no same-cycle refill while freeing).
- FSM states IDLE, GO, WAIT.
- IDLE: if sched_en and any slot full, pick grant g:
  - only one slot full -> that slot;
  - both full -> ~last_grant.
  - Load fir_x/a/w from slot g, clear full[g], set last_grant=g, go to GO.
  - Otherwise stay in IDLE.
- GO: fir_go=1 for exactly this cycle, clear watchdog, go to WAIT.
- WAIT:
  - fir_done=1 -> out_sample<=fir_out, out_chan<=last_grant, out_valid=1 on the next cycle, go to IDLE.
  - else if watchdog==TIMEOUT_CYC-1 -> set err_timeout, go to IDLE, no out_valid, result dropped.
  - else watchdog+1.
- Latency: handshake in cycle N -> fir_go in N+2 (slot empty, fir_x valid in N+2). fir_done in cycle D -> out_valid in D+1.
- Minimum per-op occupancy is 3 cycles plus engine time. Back-to-back grant: IDLE is re-entered on D+1 and a pending slot produces fir_go at D+2.
- fir_done while in IDLE or GO is ignored.
- err_timeout: err_clr clears it. If set and clear happen in the same cycle, set wins.
- sched_en=0 blocks only the IDLE->GO transition. Slots still accept.
- fir_x/a/w hold their last issued values while idle.
- Reset mid-operation (any state): all state returns to reset values on the next edge. Pending slots are discarded, no out_valid. fir_go is deasserted in the cycle after rst.
- No arithmetic on data. Pass-through only, widths unchanged.

Test Plan:
1. Reset, ch0 handshake x=0x0100, a=0x0200, w=0x0010 at cycle 5 -> fir_go at 7 with fir_x=0x0100. Engine done at 12 with fir_out=0x1234 -> out_valid at 13, out_sample=0x1234, out_chan=0, ch_ready=2'b11.
2. ch0 and ch1 valid in the same cycle, repeated 4 times -> grant order 0,1,0,1. out_chan matches each grant. Both slots' ch_ready stay low until their own grant.
3. Engine holds done low for TIMEOUT_CYC=1024 cycles -> err_timeout=1 at WAIT cycle 1024, no out_valid, busy drops. A pending ch1 is then issued. err_clr clears the flag. Assert err_clr on the same cycle as a new timeout -> flag stays 1.
4. sched_en=0 with both slots full -> no fir_go, busy=0, ch_ready=2'b00. Raise sched_en -> fir_go next cycle for ch0.
5. Assert rst in WAIT with ch1 pending -> next cycle: state IDLE, ch_ready=2'b11, out_valid=0. A subsequent fir_done is ignored.
6. Stray fir_done in IDLE, fir_out=0x7FFF -> no out_valid, out_sample unchanged.

Source files
------------

// File: rtl/anc_fir_sched.sv
// -----------------------------------------------------------------------------
// anc_fir_sched
//
// Purpose:
//   Time-shares a single FIR/LMS engine between two ANC channels. Each
//   channel drops one sample set (x, a, weight_adjust) into a depth-1 slot.
//   The scheduler grants slots round-robin and issues them to the engine over
//   a go/done handshake. It then returns the engine result tagged with the
//   channel that produced it. A watchdog aborts an operation whose done
//   pulse never arrives.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   sched_en        1 = new grants allowed, 0 = hold (in-flight op completes)
//   ch_valid[1:0]   per-channel sample-set valid
//   ch_ready[1:0]   per-channel slot empty
//   chN_x/a/w       channel reference / desired / weight_adjust (signed, DW)
//   fir_go          one-cycle start pulse to the engine
//   fir_x/a/w       issued operands, stable from fir_go until the op ends
//   fir_done        engine completion pulse
//   fir_out         engine result, valid with fir_done
//   out_valid       one-cycle result strobe
//   out_sample      registered result
//   out_chan        channel that produced out_sample
//   busy            scheduler not idle
//   err_timeout     sticky watchdog flag
//   err_clr         clears err_timeout (a simultaneous set wins)
// -----------------------------------------------------------------------------
module anc_fir_sched #(
  parameter int DW          = 16,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CW          = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sched_en,
  input  logic [1:0]    ch_valid,
  output logic [1:0]    ch_ready,
  input  logic [DW-1:0] ch0_x,
  input  logic [DW-1:0] ch1_x,
  input  logic [DW-1:0] ch0_a,
  input  logic [DW-1:0] ch1_a,
  input  logic [DW-1:0] ch0_w,
  input  logic [DW-1:0] ch1_w,
  output logic          fir_go,
  output logic [DW-1:0] fir_x,
  output logic [DW-1:0] fir_a,
  output logic [DW-1:0] fir_w,
  input  logic          fir_done,
  input  logic [DW-1:0] fir_out,
  output logic          out_valid,
  output logic [DW-1:0] out_sample,
  output logic          out_chan,
  output logic          busy,
  output logic          err_timeout,
  input  logic          err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GO   = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e        state_q;
  logic [1:0]    full_q;
  logic [1:0]    full_d;
  logic [DW-1:0] slot_x_q [2];
  logic [DW-1:0] slot_a_q [2];
  logic [DW-1:0] slot_w_q [2];
  logic          last_grant_q;
  logic [CW-1:0] wd_q;
  logic          fir_go_q;
  logic [DW-1:0] fir_x_q;
  logic [DW-1:0] fir_a_q;
  logic [DW-1:0] fir_w_q;
  logic          out_valid_q;
  logic [DW-1:0] out_sample_q;
  logic          out_chan_q;
  logic          busy_q;
  logic          err_q;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [1:0]    accept_s;
  logic          grant_valid_s;
  logic          grant_s;
  logic          wd_last_s;
  logic          err_set_s;

  // Slot accept qualifiers: a slot only takes a new set while it is empty.
  assign accept_s = ch_valid & ~full_q;

  // A grant happens only from IDLE, with scheduling enabled and work pending.
  assign grant_valid_s = sched_en && (state_q == ST_IDLE) && (full_q != 2'b00);

  // Watchdog terminal count: the last WAIT cycle before the op is abandoned.
  assign wd_last_s = (wd_q == CW'(TIMEOUT_CYC - 1));

  // Timeout fires only if done is absent on that terminal WAIT cycle.
  assign err_set_s = (state_q == ST_WAIT) && !fir_done && wd_last_s;

  // Round-robin pick: a lone pending slot wins; on a tie the slot not served
  // last wins. last_grant resets to 1 so ch0 takes the very first tie.
  always_comb begin
    grant_s = 1'b0;
    case (full_q)
      2'b01:   grant_s = 1'b0;
      2'b10:   grant_s = 1'b1;
      2'b11:   grant_s = ~last_grant_q;
      default: grant_s = 1'b0;
    endcase
  end

  // Slot occupancy next state: fill on accept, drain on grant. Both cannot
  // hit the same slot in one cycle since accept needs empty and grant needs full.
  always_comb begin
    full_d = full_q;
    for (int i = 0; i < 2; i++) begin
      if (accept_s[i]) begin
        full_d[i] = 1'b1;
      end else if (grant_valid_s && (grant_s == i[0])) begin
        full_d[i] = 1'b0;
      end else begin
        full_d[i] = full_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Holding slots: occupancy flags plus captured operands for each channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= 2'b00;
      slot_x_q[0] <= '0;
      slot_a_q[0] <= '0;
      slot_w_q[0] <= '0;
      slot_x_q[1] <= '0;
      slot_a_q[1] <= '0;
      slot_w_q[1] <= '0;
    end else begin
      full_q <= full_d;
      if (accept_s[0]) begin
        slot_x_q[0] <= ch0_x;
        slot_a_q[0] <= ch0_a;
        slot_w_q[0] <= ch0_w;
      end
      if (accept_s[1]) begin
        slot_x_q[1] <= ch1_x;
        slot_a_q[1] <= ch1_a;
        slot_w_q[1] <= ch1_w;
      end
    end
  end

  // Scheduler FSM with all engine-side and result outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      wd_q         <= '0;
      fir_go_q     <= 1'b0;
      fir_x_q      <= '0;
      fir_a_q      <= '0;
      fir_w_q      <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      out_chan_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      fir_go_q    <= 1'b0;
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid_s) begin
            // fir_go is raised here so it is high exactly during GO.
            fir_x_q      <= slot_x_q[grant_s];
            fir_a_q      <= slot_a_q[grant_s];
            fir_w_q      <= slot_w_q[grant_s];
            last_grant_q <= grant_s;
            fir_go_q     <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_GO;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_GO: begin
          // fir_done here is a stray pulse from a previous op; ignore it.
          wd_q    <= '0;
          busy_q  <= 1'b1;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fir_done) begin
            out_sample_q <= fir_out;
            out_chan_q   <= last_grant_q;
            out_valid_q  <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= ST_IDLE;
          end else if (wd_last_s) begin
            // Abandon the op; the result is dropped and no strobe is given.
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            wd_q    <= wd_q + CW'(1);
            busy_q  <= 1'b1;
            state_q <= ST_WAIT;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky timeout flag; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_set_s) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ch_ready    = ~full_q;
  assign fir_go      = fir_go_q;
  assign fir_x       = fir_x_q;
  assign fir_a       = fir_a_q;
  assign fir_w       = fir_w_q;
  assign out_valid   = out_valid_q;
  assign out_sample  = out_sample_q;
  assign out_chan    = out_chan_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_anc_fir_sched.sv
// -----------------------------------------------------------------------------
// tb_anc_fir_sched
//
// Self-checking bench for anc_fir_sched. The bench plays the engine: each
// time it pulses fir_done it pushes the expected {channel, sample} onto a
// scoreboard. A negedge monitor pops and compares every out_valid. Direct
// checks cover latency, arbitration order, watchdog, sched_en, reset and
// stray-done behaviour.
// -----------------------------------------------------------------------------
module tb_anc_fir_sched;

  localparam int DW = 16;
  localparam int TO = 1024;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sched_en = 1'b1;
  logic [1:0]    ch_valid = 2'b00;
  logic [1:0]    ch_ready;
  logic [DW-1:0] ch0_x = '0, ch1_x = '0, ch0_a = '0, ch1_a = '0, ch0_w = '0, ch1_w = '0;
  logic          fir_go;
  logic [DW-1:0] fir_x, fir_a, fir_w;
  logic          fir_done = 1'b0;
  logic [DW-1:0] fir_out = '0;
  logic          out_valid;
  logic [DW-1:0] out_sample;
  logic          out_chan;
  logic          busy;
  logic          err_timeout;
  logic          err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW:0] sb [$];

  always #5 clk = ~clk;

  anc_fir_sched #(.DW(DW), .TIMEOUT_CYC(TO), .CW(CW)) dut (
    .clk(clk), .rst(rst), .sched_en(sched_en),
    .ch_valid(ch_valid), .ch_ready(ch_ready),
    .ch0_x(ch0_x), .ch1_x(ch1_x), .ch0_a(ch0_a), .ch1_a(ch1_a),
    .ch0_w(ch0_w), .ch1_w(ch1_w),
    .fir_go(fir_go), .fir_x(fir_x), .fir_a(fir_a), .fir_w(fir_w),
    .fir_done(fir_done), .fir_out(fir_out),
    .out_valid(out_valid), .out_sample(out_sample), .out_chan(out_chan),
    .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    ch_valid = 2'b00;
    fir_done = 1'b0;
    err_clr  = 1'b0;
    sched_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Drive a one-cycle handshake; returns in the cycle after it was sampled.
  task automatic present(input logic [1:0] v,
                         input logic [DW-1:0] x0, input logic [DW-1:0] a0, input logic [DW-1:0] w0,
                         input logic [DW-1:0] x1, input logic [DW-1:0] a1, input logic [DW-1:0] w1);
    ch0_x = x0; ch0_a = a0; ch0_w = w0;
    ch1_x = x1; ch1_a = a1; ch1_w = w1;
    ch_valid = v;
    tick();
    ch_valid = 2'b00;
  endtask

  task automatic wait_go(input int max_cyc);
    int n = 0;
    while (fir_go !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    check_val("fir_go_seen", {31'd0, fir_go}, 32'd1);
  endtask

  // Engine completion: expectation is queued as the pulse is driven.
  task automatic engine_done(input logic ch, input logic [DW-1:0] res);
    fir_done = 1'b1;
    fir_out  = res;
    sb.push_back({ch, res});
    tick();
    fir_done = 1'b0;
    check_val("out_valid_after_done", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run_op(input logic ch, input logic [DW-1:0] x, input logic [DW-1:0] a,
                        input logic [DW-1:0] w, input logic [DW-1:0] res, input int lat);
    wait_go(20);
    check_val("fir_x", {16'd0, fir_x}, {16'd0, x});
    check_val("fir_a", {16'd0, fir_a}, {16'd0, a});
    check_val("fir_w", {16'd0, fir_w}, {16'd0, w});
    tick();
    check_val("fir_go_one_cycle", {31'd0, fir_go}, 32'd0);
    repeat (lat) tick();
    engine_done(ch, res);
  endtask

  // Result monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        logic [DW:0] e;
        e = sb.pop_front();
        check_val("sb_out_chan", {31'd0, out_chan}, {31'd0, e[DW]});
        check_val("sb_out_sample", {16'd0, out_sample}, {16'd0, e[DW-1:0]});
      end
    end
  end

  initial begin
    // ---- 1: reset state and basic latency ----
    apply_reset();
    check_val("rst_ch_ready", {30'd0, ch_ready}, 32'd3);
    check_val("rst_fir_go", {31'd0, fir_go}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_err", {31'd0, err_timeout}, 32'd0);
    check_val("rst_fir_x", {16'd0, fir_x}, 32'd0);
    check_val("rst_out_sample", {16'd0, out_sample}, 32'd0);
    present(2'b01, 16'h0100, 16'h0200, 16'h0010, 16'h0, 16'h0, 16'h0);
    check_val("t1_ready_n1", {30'd0, ch_ready}, 32'd2);
    check_val("t1_go_n1", {31'd0, fir_go}, 32'd0);
    tick();
    check_val("t1_go_n2", {31'd0, fir_go}, 32'd1);
    check_val("t1_ready_n2", {30'd0, ch_ready}, 32'd3);
    check_val("t1_busy_n2", {31'd0, busy}, 32'd1);
    run_op(1'b0, 16'h0100, 16'h0200, 16'h0010, 16'h1234, 4);
    check_val("t1_out_sample", {16'd0, out_sample}, 32'h1234);
    check_val("t1_out_chan", {31'd0, out_chan}, 32'd0);
    check_val("t1_ready_end", {30'd0, ch_ready}, 32'd3);
    check_val("t1_busy_end", {31'd0, busy}, 32'd0);

    // ---- 2: round-robin on simultaneous requests ----
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      present(2'b11, 16'(16'h1000 + k), 16'(16'h2000 + k), 16'(16'h3000 + k),
                     16'(16'h4000 + k), 16'(16'h5000 + k), 16'(16'h6000 + k));
      check_val("rr_ready_both_full", {30'd0, ch_ready}, 32'd0);
      wait_go(20);
      check_val("rr_ready_ch0go", {30'd0, ch_ready}, 32'd1);
      run_op(1'b0, 16'(16'h1000 + k), 16'(16'h2000 + k), 16'(16'h3000 + k), 16'(16'hA000 + k), k);
      wait_go(20);
      check_val("rr_ready_ch1go", {30'd0, ch_ready}, 32'd3);
      run_op(1'b1, 16'(16'h4000 + k), 16'(16'h5000 + k), 16'(16'h6000 + k), 16'(16'hB000 + k), 1);
    end

    // ---- 3: watchdog timeout, pending issue, err_clr and set-wins ----
    apply_reset();
    present(2'b01, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0, 16'h0, 16'h0);
    wait_go(20);
    tick();
    present(2'b10, 16'h0, 16'h0, 16'h0, 16'h1111, 16'h2222, 16'h3333);
    repeat (TO - 2) tick();
    check_val("to_err_before", {31'd0, err_timeout}, 32'd0);
    check_val("to_busy_before", {31'd0, busy}, 32'd1);
    tick();
    check_val("to_err_set", {31'd0, err_timeout}, 32'd1);
    check_val("to_busy_drop", {31'd0, busy}, 32'd0);
    check_val("to_no_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check_val("to_pending_go", {31'd0, fir_go}, 32'd1);
    run_op(1'b1, 16'h1111, 16'h2222, 16'h3333, 16'h0FF0, 2);
    check_val("to_err_sticky", {31'd0, err_timeout}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_val("to_err_clr", {31'd0, err_timeout}, 32'd0);
    present(2'b01, 16'h0D0D, 16'h0E0E, 16'h0F0F, 16'h0, 16'h0, 16'h0);
    wait_go(20);
    repeat (TO) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_val("to_set_wins", {31'd0, err_timeout}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_val("to_err_clr2", {31'd0, err_timeout}, 32'd0);

    // ---- 4: sched_en gating ----
    apply_reset();
    sched_en = 1'b0;
    present(2'b11, 16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h0555, 16'h0666);
    repeat (3) tick();
    check_val("en_no_go", {31'd0, fir_go}, 32'd0);
    check_val("en_busy", {31'd0, busy}, 32'd0);
    check_val("en_ready", {30'd0, ch_ready}, 32'd0);
    sched_en = 1'b1;
    tick();
    check_val("en_go_next", {31'd0, fir_go}, 32'd1);
    run_op(1'b0, 16'h0111, 16'h0222, 16'h0333, 16'h7A7A, 0);
    run_op(1'b1, 16'h0444, 16'h0555, 16'h0666, 16'h7B7B, 3);

    // ---- 5: reset in WAIT with ch1 pending ----
    apply_reset();
    present(2'b01, 16'h0ABC, 16'h0DEF, 16'h0123, 16'h0, 16'h0, 16'h0);
    wait_go(20);
    tick();
    present(2'b10, 16'h0, 16'h0, 16'h0, 16'h0456, 16'h0789, 16'h0321);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mr_ready", {30'd0, ch_ready}, 32'd3);
    check_val("mr_busy", {31'd0, busy}, 32'd0);
    check_val("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("mr_fir_go", {31'd0, fir_go}, 32'd0);
    fir_done = 1'b1;
    fir_out  = 16'hBEEF;
    tick();
    fir_done = 1'b0;
    check_val("mr_done_ignored", {31'd0, out_valid}, 32'd0);
    check_val("mr_out_sample", {16'd0, out_sample}, 32'd0);
    repeat (3) tick();
    check_val("mr_pending_dropped", {31'd0, busy}, 32'd0);

    // ---- 6: stray fir_done in IDLE and GO ----
    apply_reset();
    present(2'b01, 16'h0001, 16'h0002, 16'h0003, 16'h0, 16'h0, 16'h0);
    run_op(1'b0, 16'h0001, 16'h0002, 16'h0003, 16'h5A5A, 1);
    tick();
    fir_done = 1'b1;
    fir_out  = 16'h7FFF;
    tick();
    fir_done = 1'b0;
    check_val("stray_idle_valid", {31'd0, out_valid}, 32'd0);
    check_val("stray_idle_sample", {16'd0, out_sample}, 32'h5A5A);
    check_val("stray_idle_busy", {31'd0, busy}, 32'd0);
    present(2'b10, 16'h0, 16'h0, 16'h0, 16'h0004, 16'h0005, 16'h0006);
    wait_go(20);
    fir_done = 1'b1;
    fir_out  = 16'h7FFF;
    tick();
    fir_done = 1'b0;
    check_val("stray_go_busy", {31'd0, busy}, 32'd1);
    tick();
    check_val("stray_go_valid", {31'd0, out_valid}, 32'd0);
    engine_done(1'b1, 16'h6B6B);
    tick();

    check_val("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
